// File: rtl/axi_ar_arbiter.sv
// Two-master AXI read-address arbiter with round-robin grant, burst-long hold
// and beat counting against ARLEN to flag burst-length mismatches.
module axi_ar_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   ARID_M0,
  input  logic [ADDR_W-1:0] ARADDR_M0,
  input  logic [LEN_W-1:0]  ARLEN_M0,
  input  logic [2:0]        ARSIZE_M0,
  input  logic [1:0]        ARBURST_M0,
  input  logic              ARVALID_M0,
  output logic              ARREADY_M0,
  input  logic [ID_W-1:0]   ARID_M1,
  input  logic [ADDR_W-1:0] ARADDR_M1,
  input  logic [LEN_W-1:0]  ARLEN_M1,
  input  logic [2:0]        ARSIZE_M1,
  input  logic [1:0]        ARBURST_M1,
  input  logic              ARVALID_M1,
  output logic              ARREADY_M1,
  output logic [ID_W-1:0]   ARID_S,
  output logic [ADDR_W-1:0] ARADDR_S,
  output logic [LEN_W-1:0]  ARLEN_S,
  output logic [2:0]        ARSIZE_S,
  output logic [1:0]        ARBURST_S,
  output logic              ARVALID_S,
  input  logic              ARREADY_S,
  input  logic [ID_W-1:0]   RID_S,
  input  logic [DATA_W-1:0] RDATA_S,
  input  logic [1:0]        RRESP_S,
  input  logic              RLAST_S,
  input  logic              RVALID_S,
  output logic              RREADY_S,
  output logic [ID_W-1:0]   RID_M0,
  output logic [DATA_W-1:0] RDATA_M0,
  output logic [1:0]        RRESP_M0,
  output logic              RLAST_M0,
  output logic              RVALID_M0,
  input  logic              RREADY_M0,
  output logic [ID_W-1:0]   RID_M1,
  output logic [DATA_W-1:0] RDATA_M1,
  output logic [1:0]        RRESP_M1,
  output logic              RLAST_M1,
  output logic              RVALID_M1,
  input  logic              RREADY_M1,
  output logic              len_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W:0]     beat_cnt_q, beat_cnt_d;
  logic               len_err_q, len_err_d;

  logic               sel_arvalid;
  logic [ID_W-1:0]    sel_arid;
  logic [ADDR_W-1:0]  sel_araddr;
  logic [LEN_W-1:0]   sel_arlen;
  logic [2:0]         sel_arsize;
  logic [1:0]         sel_arburst;
  logic               sel_rready;
  logic               r_beat;
  logic [LEN_W+1:0]   beat_inc;
  logic [LEN_W+1:0]   len_total;

  always_comb begin
    sel_arvalid = ARVALID_M0;
    sel_arid    = ARID_M0;
    sel_araddr  = ARADDR_M0;
    sel_arlen   = ARLEN_M0;
    sel_arsize  = ARSIZE_M0;
    sel_arburst = ARBURST_M0;
    sel_rready  = RREADY_M0;
    if (grant_q) begin
      sel_arvalid = ARVALID_M1;
      sel_arid    = ARID_M1;
      sel_araddr  = ARADDR_M1;
      sel_arlen   = ARLEN_M1;
      sel_arsize  = ARSIZE_M1;
      sel_arburst = ARBURST_M1;
      sel_rready  = RREADY_M1;
    end
  end

  // Extra headroom bit so the comparison stays exact even once the counter saturates.
  assign r_beat    = (state_q == DATA) && RVALID_S && sel_rready;
  assign beat_inc  = {1'b0, beat_cnt_q} + 1'b1;
  assign len_total = {2'b00, len_q} + 1'b1;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      len_err_q    <= len_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    len_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Round-robin history only advances when both masters actually contend.
        if (ARVALID_M0 && ARVALID_M1) begin
          grant_d      = ~last_grant_q;
          last_grant_d = ~last_grant_q;
          state_d      = ADDR;
        end else if (ARVALID_M0) begin
          grant_d = 1'b0;
          state_d = ADDR;
        end else if (ARVALID_M1) begin
          grant_d = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (sel_arvalid && ARREADY_S) begin
          len_d      = sel_arlen;
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (r_beat) begin
          if (!(&beat_cnt_q)) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
          if (RLAST_S) begin
            state_d   = IDLE;
            len_err_d = (beat_inc != len_total);
          end else begin
            len_err_d = (beat_inc == len_total);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ARVALID_S  = 1'b0;
    ARID_S     = '0;
    ARADDR_S   = '0;
    ARLEN_S    = '0;
    ARSIZE_S   = '0;
    ARBURST_S  = '0;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    RREADY_S   = 1'b0;
    RID_M0     = '0;
    RDATA_M0   = '0;
    RRESP_M0   = '0;
    RLAST_M0   = 1'b0;
    RVALID_M0  = 1'b0;
    RID_M1     = '0;
    RDATA_M1   = '0;
    RRESP_M1   = '0;
    RLAST_M1   = 1'b0;
    RVALID_M1  = 1'b0;
    if (state_q == ADDR) begin
      ARVALID_S = sel_arvalid;
      ARID_S    = sel_arid;
      ARADDR_S  = sel_araddr;
      ARLEN_S   = sel_arlen;
      ARSIZE_S  = sel_arsize;
      ARBURST_S = sel_arburst;
      if (grant_q) ARREADY_M1 = ARREADY_S;
      else         ARREADY_M0 = ARREADY_S;
    end
    if (state_q == DATA) begin
      RREADY_S = sel_rready;
      if (grant_q) begin
        RID_M1    = RID_S;
        RDATA_M1  = RDATA_S;
        RRESP_M1  = RRESP_S;
        RLAST_M1  = RLAST_S;
        RVALID_M1 = RVALID_S;
      end else begin
        RID_M0    = RID_S;
        RDATA_M0  = RDATA_S;
        RRESP_M0  = RRESP_S;
        RLAST_M0  = RLAST_S;
        RVALID_M0 = RVALID_S;
      end
    end
  end

  assign len_err = len_err_q;

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Directed bench for axi_ar_arbiter: grant order, burst routing, length
// error pulses, address backpressure and asynchronous reset.
module tb_axi_ar_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 4;

  logic              ACLK = 1'b0;
  logic              ARESETn;
  logic [ID_W-1:0]   ARID_M0, ARID_M1, ARID_S, RID_S, RID_M0, RID_M1;
  logic [ADDR_W-1:0] ARADDR_M0, ARADDR_M1, ARADDR_S;
  logic [LEN_W-1:0]  ARLEN_M0, ARLEN_M1, ARLEN_S;
  logic [2:0]        ARSIZE_M0, ARSIZE_M1, ARSIZE_S;
  logic [1:0]        ARBURST_M0, ARBURST_M1, ARBURST_S;
  logic              ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
  logic              ARVALID_S, ARREADY_S;
  logic [DATA_W-1:0] RDATA_S, RDATA_M0, RDATA_M1;
  logic [1:0]        RRESP_S, RRESP_M0, RRESP_M1;
  logic              RLAST_S, RVALID_S, RREADY_S;
  logic              RLAST_M0, RVALID_M0, RREADY_M0;
  logic              RLAST_M1, RVALID_M1, RREADY_M1;
  logic              len_err;

  int checkCount = 0;
  int passCount  = 0;

  axi_ar_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
    .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
    .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .len_err(len_err)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic cycle();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clearInputs();
    {ARID_M0, ARADDR_M0, ARLEN_M0, ARVALID_M0} = '0;
    {ARID_M1, ARADDR_M1, ARLEN_M1, ARVALID_M1} = '0;
    ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'd1;
    ARSIZE_M1 = 3'd3; ARBURST_M1 = 2'd2;
    ARREADY_S = 1'b0;
    {RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S} = '0;
    RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
  endtask

  task automatic applyStimulus(input int m, input logic v, input logic [ADDR_W-1:0] a,
                               input logic [LEN_W-1:0] l, input logic [ID_W-1:0] id);
    if (m == 0) begin
      ARVALID_M0 = v; ARADDR_M0 = a; ARLEN_M0 = l; ARID_M0 = id;
    end else begin
      ARVALID_M1 = v; ARADDR_M1 = a; ARLEN_M1 = l; ARID_M1 = id;
    end
  endtask

  task automatic resetDut();
    clearInputs();
    ARESETn = 1'b0;
    @(posedge ACLK);
    #3 ARESETn = 1'b1;
    cycle();
  endtask

  // Drives one slave beat to master m (whose RREADY is already high) and checks routing.
  task automatic sendBeat(input int m, input logic [DATA_W-1:0] d, input logic last);
    RVALID_S = 1'b1; RDATA_S = d; RLAST_S = last; RRESP_S = 2'd1;
    #1;
    checkOutput("beat_rready_s", RREADY_S, 1'b1);
    checkOutput("beat_rvalid_gnt", (m == 0) ? RVALID_M0 : RVALID_M1, 1'b1);
    checkOutput("beat_rvalid_other", (m == 0) ? RVALID_M1 : RVALID_M0, 1'b0);
    checkOutput("beat_rdata", (m == 0) ? RDATA_M0 : RDATA_M1, d);
    checkOutput("beat_rlast", (m == 0) ? RLAST_M0 : RLAST_M1, last);
    checkOutput("beat_rresp", (m == 0) ? RRESP_M0 : RRESP_M1, 2'd1);
    cycle();
    RVALID_S = 1'b0; RLAST_S = 1'b0;
  endtask

  // From ADDR: handshake the granted master m, then deliver one RLAST beat.
  task automatic singleBurst(input int m, input logic [DATA_W-1:0] d);
    ARREADY_S = 1'b1;
    #1;
    checkOutput("sb_arready_gnt", (m == 0) ? ARREADY_M0 : ARREADY_M1, 1'b1);
    checkOutput("sb_arready_other", (m == 0) ? ARREADY_M1 : ARREADY_M0, 1'b0);
    cycle();
    ARREADY_S = 1'b1;
    #1;
    checkOutput("sb_data_arvalid_s", ARVALID_S, 1'b0);
    checkOutput("sb_data_arready_m0", ARREADY_M0, 1'b0);
    checkOutput("sb_data_arready_m1", ARREADY_M1, 1'b0);
    ARREADY_S = 1'b0;
    sendBeat(m, d, 1'b1);
  endtask

  task automatic startBurst(input int m, input logic [ADDR_W-1:0] a,
                            input logic [LEN_W-1:0] l, input logic [ID_W-1:0] id);
    applyStimulus(m, 1'b1, a, l, id);
    cycle();
    checkOutput("start_araddr_s", ARADDR_S, a);
    checkOutput("start_arlen_s", ARLEN_S, l);
    checkOutput("start_arid_s", ARID_S, id);
    ARREADY_S = 1'b1;
    #1;
    cycle();
    ARREADY_S = 1'b0;
    applyStimulus(m, 1'b0, a, l, id);
  endtask

  initial begin
    int sent;
    clearInputs();
    ARESETn = 1'b0;
    ARVALID_M0 = 1'b1; RVALID_S = 1'b1; RREADY_M0 = 1'b1;
    #2;
    checkOutput("rst_arvalid_s", ARVALID_S, 1'b0);
    checkOutput("rst_arready_m0", ARREADY_M0, 1'b0);
    checkOutput("rst_rready_s", RREADY_S, 1'b0);
    checkOutput("rst_rvalid_m0", RVALID_M0, 1'b0);
    checkOutput("rst_len_err", len_err, 1'b0);
    checkOutput("rst_araddr_s", ARADDR_S, 32'h0);
    resetDut();

    // Single request from M0, ARLEN=0.
    applyStimulus(0, 1'b1, 32'h0001_0040, 4'd0, 4'd3);
    #1;
    checkOutput("t1_idle_arvalid_s", ARVALID_S, 1'b0);
    cycle();
    checkOutput("t1_arvalid_s", ARVALID_S, 1'b1);
    checkOutput("t1_araddr_s", ARADDR_S, 32'h0001_0040);
    checkOutput("t1_arid_s", ARID_S, 4'd3);
    checkOutput("t1_arsize_s", ARSIZE_S, 3'd2);
    checkOutput("t1_arready_m0_wait", ARREADY_M0, 1'b0);
    ARREADY_S = 1'b1;
    #1;
    checkOutput("t1_arready_m0", ARREADY_M0, 1'b1);
    checkOutput("t1_arready_m1", ARREADY_M1, 1'b0);
    cycle();
    ARREADY_S = 1'b0;
    applyStimulus(0, 1'b0, 32'h0001_0040, 4'd0, 4'd3);
    RREADY_M0 = 1'b1;
    sendBeat(0, 32'hCAFE_0001, 1'b1);
    checkOutput("t1_len_err", len_err, 1'b0);
    RVALID_S = 1'b1;
    #1;
    checkOutput("t1_idle_rready_s", RREADY_S, 1'b0);
    checkOutput("t1_idle_rvalid_m0", RVALID_M0, 1'b0);
    RVALID_S = 1'b0;

    // Three contentions after reset: M0, M1, M0.
    resetDut();
    applyStimulus(0, 1'b1, 32'h0000_0100, 4'd0, 4'd1);
    applyStimulus(1, 1'b1, 32'h0000_0200, 4'd0, 4'd2);
    RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
    cycle();
    checkOutput("t2_first_grant", ARADDR_S, 32'h0000_0100);
    singleBurst(0, 32'h1111_0000);
    cycle();
    checkOutput("t2_second_grant", ARADDR_S, 32'h0000_0200);
    checkOutput("t2_second_arsize", ARSIZE_S, 3'd3);
    singleBurst(1, 32'h2222_0000);
    cycle();
    checkOutput("t2_third_grant", ARADDR_S, 32'h0000_0100);
    singleBurst(0, 32'h3333_0000);

    // M1 burst ARLEN=3 with RREADY_M1 toggling.
    resetDut();
    startBurst(1, 32'h0000_3000, 4'd3, 4'd5);
    sent = 0;
    RVALID_S = 1'b1; RID_S = 4'd5;
    for (int i = 0; i < 20 && sent < 4; i++) begin
      RREADY_M1 = ((i % 2) == 0);
      RDATA_S = 32'h0000_D000 + sent;
      RLAST_S = (sent == 3);
      #1;
      checkOutput("t3_rvalid_m0", RVALID_M0, 1'b0);
      checkOutput("t3_rready_s", RREADY_S, RREADY_M1);
      if (RREADY_M1) begin
        checkOutput("t3_rlast_m1", RLAST_M1, (sent == 3));
        checkOutput("t3_rdata_m1", RDATA_M1, 32'h0000_D000 + sent);
        checkOutput("t3_rid_m1", RID_M1, 4'd5);
        sent++;
      end
      cycle();
    end
    RVALID_S = 1'b0; RLAST_S = 1'b0; RREADY_M1 = 1'b1;
    checkOutput("t3_len_err", len_err, 1'b0);
    RVALID_S = 1'b1;
    #1;
    checkOutput("t3_idle_rready_s", RREADY_S, 1'b0);
    RVALID_S = 1'b0;

    // ARLEN=3 but RLAST on beat 2.
    RREADY_M0 = 1'b1;
    startBurst(0, 32'h0000_4000, 4'd3, 4'd1);
    sendBeat(0, 32'h0000_00A1, 1'b0);
    checkOutput("t4a_len_err_b1", len_err, 1'b0);
    sendBeat(0, 32'h0000_00A2, 1'b1);
    checkOutput("t4a_len_err", len_err, 1'b1);
    cycle();
    checkOutput("t4a_len_err_clear", len_err, 1'b0);
    RVALID_S = 1'b1;
    #1;
    checkOutput("t4a_idle_rready_s", RREADY_S, 1'b0);
    RVALID_S = 1'b0;

    // ARLEN=1 with no RLAST on beat 2, RLAST on beat 3.
    startBurst(0, 32'h0000_5000, 4'd1, 4'd2);
    sendBeat(0, 32'h0000_00B1, 1'b0);
    checkOutput("t4b_len_err_b1", len_err, 1'b0);
    sendBeat(0, 32'h0000_00B2, 1'b0);
    checkOutput("t4b_len_err_b2", len_err, 1'b1);
    sendBeat(0, 32'h0000_00B3, 1'b1);
    checkOutput("t4b_len_err_b3", len_err, 1'b1);
    cycle();
    checkOutput("t4b_len_err_clear", len_err, 1'b0);

    // Address-phase backpressure while M1 requests.
    applyStimulus(0, 1'b1, 32'h0000_6000, 4'd0, 4'd2);
    cycle();
    applyStimulus(1, 1'b1, 32'h0000_7000, 4'd0, 4'd4);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("t5_hold_araddr", ARADDR_S, 32'h0000_6000);
      checkOutput("t5_hold_arvalid", ARVALID_S, 1'b1);
      checkOutput("t5_hold_arready_m1", ARREADY_M1, 1'b0);
      cycle();
    end
    RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
    ARREADY_S = 1'b1;
    #1;
    checkOutput("t5_arready_m0", ARREADY_M0, 1'b1);
    checkOutput("t5_arready_m1", ARREADY_M1, 1'b0);
    cycle();
    ARREADY_S = 1'b0;
    applyStimulus(0, 1'b0, 32'h0000_6000, 4'd0, 4'd2);
    sendBeat(0, 32'h0000_6666, 1'b1);
    cycle();
    checkOutput("t5_m1_grant", ARADDR_S, 32'h0000_7000);
    checkOutput("t5_m1_arvalid", ARVALID_S, 1'b1);
    singleBurst(1, 32'h0000_7777);

    // Reset in the middle of a 4-beat burst, then in the address phase.
    resetDut();
    RREADY_M0 = 1'b1;
    applyStimulus(0, 1'b1, 32'h0000_8000, 4'd3, 4'd1);
    applyStimulus(1, 1'b1, 32'h0000_9000, 4'd3, 4'd2);
    cycle();
    checkOutput("t6_first_grant", ARADDR_S, 32'h0000_8000);
    ARREADY_S = 1'b1;
    #1;
    cycle();
    ARREADY_S = 1'b0;
    sendBeat(0, 32'h0000_00E1, 1'b0);
    RVALID_S = 1'b1; RDATA_S = 32'h0000_00E2;
    #1;
    checkOutput("t6_pre_rready_s", RREADY_S, 1'b1);
    #1 ARESETn = 1'b0;
    #1;
    checkOutput("t6_rst_rready_s", RREADY_S, 1'b0);
    checkOutput("t6_rst_rvalid_m0", RVALID_M0, 1'b0);
    checkOutput("t6_rst_arvalid_s", ARVALID_S, 1'b0);
    RVALID_S = 1'b0;
    @(posedge ACLK);
    #3 ARESETn = 1'b1;
    cycle();
    checkOutput("t6_after_rst_grant", ARADDR_S, 32'h0000_8000);
    ARREADY_S = 1'b1;
    #1;
    checkOutput("t6_addr_arready_m0", ARREADY_M0, 1'b1);
    ARESETn = 1'b0;
    #1;
    checkOutput("t6_rst2_arready_m0", ARREADY_M0, 1'b0);
    checkOutput("t6_rst2_arvalid_s", ARVALID_S, 1'b0);
    clearInputs();
    #2 ARESETn = 1'b1;
    cycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/axi_ar_arbiter.md
Name: axi_ar_arbiter

Overview:
- Two-master read-address arbiter placed in front of the AXI slave address decoder; M0 is the instruction fetch port, M1 the data port.
- Grants the shared AR channel to one master at a time using round-robin priority.
- Holds the grant through the whole read burst so R-channel beats return to the granting master.
- Counts beats against ARLEN and flags burst-length mismatches.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read data width
ID_W, 4, transaction ID width
LEN_W, 4, burst length field width (beats = ARLEN+1)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
ARID_M0/ARID_M1  in  ID_W  master AR ID
ARADDR_M0/ARADDR_M1  in  ADDR_W  master AR address
ARLEN_M0/ARLEN_M1  in  LEN_W  master burst length
ARSIZE_M0/ARSIZE_M1  in  3  master burst size
ARBURST_M0/ARBURST_M1  in  2  master burst type
ARVALID_M0/ARVALID_M1  in  1  master AR valid
ARREADY_M0/ARREADY_M1  out  1  AR ready to each master
ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  out  ID_W/ADDR_W/LEN_W/3/2  muxed AR payload to decoder
ARVALID_S  out  1  muxed AR valid to decoder
ARREADY_S  in  1  AR ready from decoder
RID_S  in  ID_W  read ID from slave side
RDATA_S  in  DATA_W  read data from slave side
RRESP_S  in  2  read response from slave side
RLAST_S  in  1  last beat from slave side
RVALID_S  in  1  read valid from slave side
RREADY_S  out  1  read ready to slave side
RID_M0/RID_M1, RDATA_M0/RDATA_M1, RRESP_M0/RRESP_M1, RLAST_M0/RLAST_M1  out  ID_W/DATA_W/2/1  R payload per master
RVALID_M0/RVALID_M1  out  1  read valid per master
RREADY_M0/RREADY_M1  in  1  read ready per master
len_err  out  1  one-cycle pulse on burst-length mismatch

Behaviour:
- One clock ACLK; reset ARESETn is asynchronous, active-low.
- Reset state:
  - FSM in IDLE, grant=0, last_grant=1 (M0 preferred first), beat_cnt=0.
  - Outputs ARVALID_S, ARREADY_M*, RREADY_S, RVALID_M*, len_err all 0.
  - Payload outputs are 0 while not granted.
- FSM states IDLE, ADDR, DATA.
- IDLE:
  - Only ARVALID_M0: register grant=0, go to ADDR.
  - Only ARVALID_M1: register grant=1, go to ADDR.
  - Both asserted: grant = ~last_grant, and last_grant updates to the new grant.
  - Latency from ARVALID to ARVALID_S is exactly 1 cycle.
  - No AR or R signals are forwarded in IDLE.
- ADDR:
  - ARVALID_S = ARVALID of the granted master; AR payload muxed from the granted master.
  - ARREADY of the granted master = ARREADY_S; ARREADY of the other master = 0.
  - On ARVALID_S & ARREADY_S: latch ARLEN into len_q, clear beat_cnt, go to DATA.
  - If the granted master drops ARVALID (protocol violation), remain in ADDR; no grant change.
- DATA:
  - ARVALID_S=0 and both ARREADY_M*=0; a new master request waits.
  - R payload and RVALID_S are routed to the granted master; RREADY_S = RREADY of the granted master.
  - The other master sees RVALID=0.
  - Each RVALID_S & RREADY_S beat increments beat_cnt (width LEN_W+1, no wrap).
  - On a beat with RLAST_S=1, go to IDLE the next cycle.
  - A new grant may be issued in the IDLE cycle that follows.
- len_err pulses for 1 cycle after either of:
  - an RLAST beat where beat_cnt+1 != len_q+1 (the FSM still returns to IDLE);
  - a non-last beat where beat_cnt+1 == len_q+1 (the FSM stays in DATA until RLAST).
- RVALID_S asserted in IDLE or ADDR: RREADY_S=0, the beat is not forwarded and not counted.
- ARESETn low mid-burst: immediate return to the reset state, in-flight burst abandoned, all handshake outputs drop asynchronously.

Test Plan:
- Single request: ARVALID_M0=1, ARADDR_M0=0x0001_0040, ARLEN=0 → cycle+1 ARVALID_S=1, ARADDR_S=0x0001_0040. Then ARREADY_S=1 → ARREADY_M0=1, one R beat with RLAST=1 reaches RDATA_M0, FSM back in IDLE, len_err=0.
- Simultaneous requests after reset: ARVALID_M0=ARVALID_M1=1 → M0 granted first. After the M0 burst completes, M1 granted; the third contention goes to M0 again.
- Burst ARLEN=3 from M1 with RREADY_M1 toggled each cycle → exactly 4 beats delivered, RVALID_M0 stays 0 throughout, RLAST_M1 only on beat 4.
- Length mismatch: ARLEN=3 but RLAST on beat 2 → len_err=1 for one cycle, FSM in IDLE. Separately, ARLEN=1 with no RLAST on beat 2 → len_err pulse, FSM stays in DATA until RLAST.
- Backpressure/hold: ARREADY_S low for 5 cycles while M1 requests mid-M0-address phase → grant remains M0, ARREADY_M1=0, M1 serviced after M0 RLAST.
- Reset mid-burst: ARESETn low during beat 2 of 4 → RREADY_S, RVALID_M*, ARVALID_S go 0 without waiting for a clock edge. After release with both requesting, M0 is granted.
